// File: rtl/sdram_refresh_arb_pkg.sv
// rtl/sdram_refresh_arb_pkg.sv - SDRAM command encodings, arbiter states and timing defaults
package sdram_params;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] SDRAM_CMD_NOP       = 4'b0111;
    localparam logic [3:0] SDRAM_CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] SDRAM_CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] SDRAM_CMD_INH       = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACCESS = 3'd2,
        S_PRE    = 3'd3,
        S_TRP    = 3'd4,
        S_REF    = 3'd5,
        S_TRFC   = 3'd6
    } state_t;

    localparam int DEF_SDRAM_ADDR_WIDTH   = 13;
    localparam int DEF_REF_INTERVAL_CYCLE = 780;
    localparam int DEF_REF_TIMER_WIDTH    = 10;
    localparam int DEF_TRP_CYCLE          = 2;
    localparam int DEF_TRFC_CYCLE         = 7;
    localparam int DEF_REF_DEBT_URGENT    = 4;

    // Wide enough for any practical tRP/tRFC wait.
    localparam int WAIT_CNT_WIDTH = 8;

    // True while the refresh engine owns the pins.
    function automatic logic is_refresh_state(state_t s);
        return (s == S_PRE) || (s == S_TRP) || (s == S_REF) || (s == S_TRFC);
    endfunction

endpackage

// File: rtl/sdram_refresh_arb_if.sv
// rtl/sdram_refresh_arb_if.sv - init, access-engine and SDRAM pin bundle for the refresh arbiter
interface sdram_refresh_arb_if #(
    parameter int SDRAM_ADDR_WIDTH = 13
);
    // init sequencer side
    logic                        init_done;
    logic                        init_cs_n;
    logic                        init_ras_n;
    logic                        init_cas_n;
    logic                        init_we_n;
    logic                        init_cke;
    logic [SDRAM_ADDR_WIDTH-1:0] init_addr;

    // access engine side
    logic                        acc_req;
    logic                        acc_gnt;
    logic                        acc_cs_n;
    logic                        acc_ras_n;
    logic                        acc_cas_n;
    logic                        acc_we_n;
    logic [SDRAM_ADDR_WIDTH-1:0] acc_addr;

    // SDRAM pins and status
    logic                        sdram_cs_n;
    logic                        sdram_ras_n;
    logic                        sdram_cas_n;
    logic                        sdram_we_n;
    logic                        sdram_cke;
    logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr;
    logic                        ref_busy;
    logic                        ref_overflow;

    modport master (
        output init_done, init_cs_n, init_ras_n, init_cas_n, init_we_n, init_cke, init_addr,
        output acc_req, acc_cs_n, acc_ras_n, acc_cas_n, acc_we_n, acc_addr,
        input  acc_gnt,
        input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke, sdram_addr,
        input  ref_busy, ref_overflow
    );

    modport slave (
        input  init_done, init_cs_n, init_ras_n, init_cas_n, init_we_n, init_cke, init_addr,
        input  acc_req, acc_cs_n, acc_ras_n, acc_cas_n, acc_we_n, acc_addr,
        output acc_gnt,
        output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke, sdram_addr,
        output ref_busy, ref_overflow
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval timer and saturating refresh-debt counter
module sdram_ref_timer
    import sdram_params::*;
#(
    parameter int REF_INTERVAL_CYCLE = DEF_REF_INTERVAL_CYCLE,
    parameter int REF_TIMER_WIDTH    = DEF_REF_TIMER_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    input  logic       i_ref_done,
    output logic [3:0] o_debt,
    output logic       o_overflow
);

    localparam logic [REF_TIMER_WIDTH-1:0] TIMER_RELOAD = REF_TIMER_WIDTH'(REF_INTERVAL_CYCLE - 1);

    logic [REF_TIMER_WIDTH-1:0] r_timer;
    logic [3:0]                 r_debt;
    logic                       r_overflow;
    logic                       w_tick;

    // One refresh obligation falls due each time the running timer wraps.
    assign w_tick = i_run && (r_timer == '0);

    // Interval down-counter, frozen until the arbiter leaves init.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= TIMER_RELOAD;
        end else if (i_run) begin
            if (r_timer == '0) begin
                r_timer <= TIMER_RELOAD;
            end else begin
                r_timer <= r_timer - REF_TIMER_WIDTH'(1);
            end
        end
    end

    // Debt grows on tick, shrinks per issued REFRESH; a coincident pair cancels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_debt     <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_tick, i_ref_done})
                2'b10: begin
                    if (r_debt == 4'hF) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_debt <= r_debt + 4'd1;
                    end
                end
                2'b01: begin
                    if (r_debt != 4'd0) begin
                        r_debt <= r_debt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_debt     = r_debt;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/sdram_refresh_arb.sv
// rtl/sdram_refresh_arb.sv - SDRAM pin owner: init pass-through, then refresh vs access arbitration
module sdram_refresh_arb
    import sdram_params::*;
#(
    parameter int SDRAM_ADDR_WIDTH   = DEF_SDRAM_ADDR_WIDTH,
    parameter int REF_INTERVAL_CYCLE = DEF_REF_INTERVAL_CYCLE,
    parameter int REF_TIMER_WIDTH    = DEF_REF_TIMER_WIDTH,
    parameter int tRP_CYCLE          = DEF_TRP_CYCLE,
    parameter int tRFC_CYCLE         = DEF_TRFC_CYCLE,
    parameter int REF_DEBT_URGENT    = DEF_REF_DEBT_URGENT
) (
    input  logic                clk,
    input  logic                reset,
    sdram_refresh_arb_if.slave  bus
);

    // Wait counters count down to zero, so a delay of N clocks loads N-2
    // (the PRE/REF command cycle and the exit cycle account for the other two).
    localparam int TRP_LOAD  = (tRP_CYCLE > 1) ? (tRP_CYCLE - 2) : 0;
    localparam int TRFC_LOAD = tRFC_CYCLE - 2;
    localparam logic [3:0] URGENT_LEVEL = 4'(REF_DEBT_URGENT);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [WAIT_CNT_WIDTH-1:0]   r_wait_cnt;
    logic [3:0]                  w_debt;
    logic                        w_overflow;
    logic [3:0]                  w_cmd;
    logic [SDRAM_ADDR_WIDTH-1:0] w_addr;
    logic                        w_cke;

    sdram_ref_timer #(
        .REF_INTERVAL_CYCLE (REF_INTERVAL_CYCLE),
        .REF_TIMER_WIDTH    (REF_TIMER_WIDTH)
    ) u_ref_timer (
        .clk        (clk),
        .reset      (reset),
        .i_run      (r_state != S_INIT),
        .i_ref_done (r_state == S_REF),
        .o_debt     (w_debt),
        .o_overflow (w_overflow)
    );

    // State register; reset abandons any refresh sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: refresh wins in idle when the access engine is quiet or debt is urgent.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: begin
                if (bus.init_done) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if ((w_debt != 4'd0) && (!bus.acc_req || (w_debt >= URGENT_LEVEL))) begin
                    w_state_next = S_PRE;
                end else if (bus.acc_req) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.acc_req) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PRE: begin
                w_state_next = (tRP_CYCLE > 1) ? S_TRP : S_REF;
            end
            S_TRP: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = S_REF;
                end
            end
            S_REF: begin
                w_state_next = S_TRFC;
            end
            S_TRFC: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    // tRP / tRFC wait counter, loaded on the command cycle and drained in the wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_PRE:   r_wait_cnt <= WAIT_CNT_WIDTH'(TRP_LOAD);
                S_REF:   r_wait_cnt <= WAIT_CNT_WIDTH'(TRFC_LOAD);
                S_TRP,
                S_TRFC: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pin mux decoded purely from state so every command is glitch-free relative to the FSM.
    always_comb begin
        w_cmd  = SDRAM_CMD_NOP;
        w_addr = '0;
        w_cke  = 1'b1;
        case (r_state)
            S_INIT: begin
                w_cmd  = {bus.init_cs_n, bus.init_ras_n, bus.init_cas_n, bus.init_we_n};
                w_addr = bus.init_addr;
                w_cke  = bus.init_cke;
            end
            S_ACCESS: begin
                w_cmd  = {bus.acc_cs_n, bus.acc_ras_n, bus.acc_cas_n, bus.acc_we_n};
                w_addr = bus.acc_addr;
            end
            S_PRE: begin
                w_cmd      = SDRAM_CMD_PRECHARGE;
                w_addr[10] = 1'b1;
            end
            S_REF: begin
                w_cmd = SDRAM_CMD_REFRESH;
            end
            default: begin
            end
        endcase
    end

    assign bus.sdram_cs_n   = w_cmd[3];
    assign bus.sdram_ras_n  = w_cmd[2];
    assign bus.sdram_cas_n  = w_cmd[1];
    assign bus.sdram_we_n   = w_cmd[0];
    assign bus.sdram_addr   = w_addr;
    assign bus.sdram_cke    = w_cke;
    assign bus.acc_gnt      = (r_state == S_ACCESS);
    assign bus.ref_busy     = is_refresh_state(r_state);
    assign bus.ref_overflow = w_overflow;

endmodule
